// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and FSM state type for the Sobel window generator
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - one-line pixel store, one-cycle registered read, read-before-write
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [PIX_W-1:0]         i_wdata,
    output logic [PIX_W-1:0]         o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rdata;

    // Storage is deliberately unreset: downstream window gating never uses
    // a location before the current frame has written it.
    // Read returns the old content when the same address is written.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 raster window generator; optional frame_err output under SOBEL_FRAME_ERR_EN
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic             win_valid,
    output logic             vsync,
    output logic             hsync
`ifdef SOBEL_FRAME_ERR_EN
    ,
    output logic             frame_err
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t           r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;

    logic             w_acc;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;

    // A pixel is taken while a frame is running, or when it opens one with sof.
    // A sof pixel is always position (0,0), even mid-frame.
    assign w_acc = pix_valid && ((r_state == ST_ACTIVE) || sof);
    assign w_col = sof ? '0 : r_col;
    assign w_row = sof ? '0 : r_row;

    // Frame FSM and raster counters; the last pixel of the frame drops back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_acc) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                if (w_row == ROW_LAST) begin
                    r_row   <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_row   <= w_row + 1'b1;
                    r_state <= ST_ACTIVE;
                end
            end else begin
                r_col   <= w_col + 1'b1;
                r_row   <= w_row;
                r_state <= ST_ACTIVE;
            end
        end
    end

    // Lines alternate between the two buffers by row parity, so while on
    // row r the same-parity buffer returns row r-2 and the other returns row r-1.
    logic [PIX_W-1:0] w_rd_even;
    logic [PIX_W-1:0] w_rd_odd;

    sobel_line_buf #(.DEPTH(IMG_W)) u_lb_even (
        .clk     (clk),
        .i_en    (w_acc),
        .i_we    (w_acc && !w_row[0]),
        .i_addr  (w_col),
        .i_wdata (pix_in),
        .o_rdata (w_rd_even)
    );

    sobel_line_buf #(.DEPTH(IMG_W)) u_lb_odd (
        .clk     (clk),
        .i_en    (w_acc),
        .i_we    (w_acc && w_row[0]),
        .i_addr  (w_col),
        .i_wdata (pix_in),
        .o_rdata (w_rd_odd)
    );

    logic             r_s1_valid;
    logic [PIX_W-1:0] r_s1_pix;
    logic             r_s1_win;
    logic             r_s1_hs;
    logic             r_s1_vs;
    logic             r_s1_odd;

    // Hold the accepted pixel and its position flags while the line buffers read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_win   <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_odd   <= 1'b0;
        end else begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_pix <= pix_in;
                r_s1_win <= (w_row >= ROW_TWO) && (w_col >= COL_TWO);
                r_s1_hs  <= (w_col == COL_TWO);
                r_s1_vs  <= (w_row == ROW_TWO) && (w_col == COL_TWO);
                r_s1_odd <= w_row[0];
            end
        end
    end

    logic [PIX_W-1:0] w_top;
    logic [PIX_W-1:0] w_mid;

    assign w_top = r_s1_odd ? w_rd_odd  : w_rd_even;
    assign w_mid = r_s1_odd ? w_rd_even : w_rd_odd;

    // Per-row column history: c0 is two columns back, c1 one column back;
    // the incoming column (w_top, w_mid, r_s1_pix) is the third.
    logic [PIX_W-1:0] r_top_c0, r_top_c1;
    logic [PIX_W-1:0] r_mid_c0, r_mid_c1;
    logic [PIX_W-1:0] r_bot_c0, r_bot_c1;
    logic [PIX_W-1:0] r_p0, r_p1, r_p2, r_p3, r_p5, r_p6, r_p7, r_p8;
    logic             r_win_valid, r_hsync, r_vsync;

    // Shift the column history on every pixel; publish a window only at
    // qualifying positions so the outputs hold steady in between.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top_c0    <= '0;
            r_top_c1    <= '0;
            r_mid_c0    <= '0;
            r_mid_c1    <= '0;
            r_bot_c0    <= '0;
            r_bot_c1    <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_p3        <= '0;
            r_p5        <= '0;
            r_p6        <= '0;
            r_p7        <= '0;
            r_p8        <= '0;
            r_win_valid <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
        end else begin
            r_win_valid <= r_s1_valid && r_s1_win;
            r_hsync     <= r_s1_valid && r_s1_win && r_s1_hs;
            r_vsync     <= r_s1_valid && r_s1_win && r_s1_vs;
            if (r_s1_valid) begin
                r_top_c0 <= r_top_c1;
                r_top_c1 <= w_top;
                r_mid_c0 <= r_mid_c1;
                r_mid_c1 <= w_mid;
                r_bot_c0 <= r_bot_c1;
                r_bot_c1 <= r_s1_pix;
                if (r_s1_win) begin
                    r_p0 <= r_top_c0;
                    r_p1 <= r_top_c1;
                    r_p2 <= w_top;
                    r_p3 <= r_mid_c0;
                    r_p5 <= w_mid;
                    r_p6 <= r_bot_c0;
                    r_p7 <= r_bot_c1;
                    r_p8 <= r_s1_pix;
                end
            end
        end
    end

    assign p0        = r_p0;
    assign p1        = r_p1;
    assign p2        = r_p2;
    assign p3        = r_p3;
    assign p5        = r_p5;
    assign p6        = r_p6;
    assign p7        = r_p7;
    assign p8        = r_p8;
    assign win_valid = r_win_valid;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;

`ifdef SOBEL_FRAME_ERR_EN
    logic r_frame_err;

    // Flag a sof that lands anywhere but the frame origin while a frame is running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= pix_valid && sof && (r_state == ST_ACTIVE) &&
                           ((r_row != '0) || (r_col != '0));
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen (8x6 image), frame_err checked under SOBEL_FRAME_ERR_EN
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
    logic       win_valid, vsync, hsync;
`ifdef SOBEL_FRAME_ERR_EN
    logic       frame_err;
`endif

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .p0        (p0),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p5        (p5),
        .p6        (p6),
        .p7        (p7),
        .p8        (p8),
        .win_valid (win_valid),
        .vsync     (vsync),
        .hsync     (hsync)
`ifdef SOBEL_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame image filled by raster position, windows cut from it.
    bit         m_active;
    int         m_row, m_col;
    logic [7:0] img [H][W];
    bit         cur_v, cur_hs, cur_vs, cur_ferr;
    logic [63:0] cur_w;
    bit         prev_v, prev_hs, prev_vs;
    logic [63:0] prev_w;
    logic [63:0] last_w;

    int          win_cnt, hs_cnt, vs_cnt, ferr_cnt;
    logic [63:0] first_w;
    logic [7:0]  w24_p8;

    typedef struct {
        int gap_pct;
        int pre_junk;
        int partial;
        int frames;
        int exp_win;
        int exp_hs;
        int exp_vs;
        int exp_ferr;
        bit chk_first;
    } scen_t;

    scen_t tbl [5];

    localparam logic [63:0] FIRST_WIN = {8'd0, 8'd1, 8'd2, 8'd8, 8'd10, 8'd16, 8'd17, 8'd18};

    task automatic model_edge(input logic v, input logic [7:0] d, input logic s);
        int r;
        int c;
        cur_v = 0; cur_hs = 0; cur_vs = 0; cur_ferr = 0; cur_w = '0;
        if (!rst) begin
            m_active = 0; m_row = 0; m_col = 0;
            prev_v = 0; prev_hs = 0; prev_vs = 0; last_w = '0;
        end else if (v && (m_active || s)) begin
            if (s) begin
                cur_ferr = m_active && (m_row != 0 || m_col != 0);
                r = 0; c = 0;
            end else begin
                r = m_row; c = m_col;
            end
            img[r][c] = d;
            if (r >= 2 && c >= 2) begin
                cur_v  = 1;
                cur_hs = (c == 2);
                cur_vs = (r == 2 && c == 2);
                cur_w  = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                          img[r-1][c-2], img[r-1][c],
                          img[r][c-2],   img[r][c-1],   img[r][c]};
            end
            m_active = 1;
            if (c == W - 1) begin
                m_col = 0;
                if (r == H - 1) begin
                    m_row = 0; m_active = 0;
                end else begin
                    m_row = r + 1;
                end
            end else begin
                m_col = c + 1; m_row = r;
            end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] dut_w;
        dut_w = {p0, p1, p2, p3, p5, p6, p7, p8};
        if (prev_v) last_w = prev_w;
        n_checks++;
        if ({win_valid, hsync, vsync} !== {prev_v, prev_v & prev_hs, prev_v & prev_vs}) begin
            n_errors++;
            $display("FAIL strobes t=%0t got v/h/vs=%b%b%b want %b%b%b", $time,
                     win_valid, hsync, vsync, prev_v, prev_v & prev_hs, prev_v & prev_vs);
        end
        n_checks++;
        if (dut_w !== last_w) begin
            n_errors++;
            $display("FAIL window t=%0t got %h want %h", $time, dut_w, last_w);
        end
`ifdef SOBEL_FRAME_ERR_EN
        n_checks++;
        if (frame_err !== cur_ferr) begin
            n_errors++;
            $display("FAIL frame_err t=%0t got %b want %b", $time, frame_err, cur_ferr);
        end
        if (frame_err) ferr_cnt++;
`endif
        if (win_valid) begin
            win_cnt++;
            if (win_cnt == 1)  first_w = dut_w;
            if (win_cnt == 24) w24_p8 = p8;
        end
        if (hsync) hs_cnt++;
        if (vsync) vs_cnt++;
        prev_v = cur_v; prev_hs = cur_hs; prev_vs = cur_vs; prev_w = cur_w;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s);
        pix_valid = v; pix_in = d; sof = s;
        @(posedge clk);
        model_edge(v, d, s);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_pix(input int gap_pct, input logic [7:0] d, input logic s);
        for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++)
            step(1'b0, 8'($urandom), 1'($urandom));
        step(1'b1, d, s);
    endtask

    task automatic send_frame(input int gap_pct, input int npix);
        for (int i = 0; i < npix; i++)
            send_pix(gap_pct, 8'((i / W) * W + (i % W)), i == 0);
    endtask

    task automatic clear_counts();
        win_cnt = 0; hs_cnt = 0; vs_cnt = 0; ferr_cnt = 0;
        first_w = '1; w24_p8 = 8'hFF;
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        tbl[0] = '{0,  0,  0,  1, 24, 4, 1, 0, 1};
        tbl[1] = '{30, 0,  0,  1, 24, 4, 1, 0, 1};
        tbl[2] = '{0,  10, 0,  1, 24, 4, 1, 0, 1};
        tbl[3] = '{20, 0,  29, 1, 33, 6, 2, 1, 1};
        tbl[4] = '{0,  0,  0,  2, 48, 8, 2, 0, 1};

        rst = 1'b0; pix_valid = 1'b0; pix_in = '0; sof = 1'b0;
        m_active = 0; m_row = 0; m_col = 0;
        prev_v = 0; prev_hs = 0; prev_vs = 0; prev_w = '0; last_w = '0;
        clear_counts();
        repeat (3) step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if ({win_valid, hsync, vsync, p0, p1, p2, p3, p5, p6, p7, p8} !== '0) begin
            n_errors++;
            $display("FAIL reset_state got %b%b%b %h want all zero", win_valid, hsync, vsync,
                     {p0, p1, p2, p3, p5, p6, p7, p8});
        end
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        for (int k = 0; k < 5; k++) begin
            clear_counts();
            for (int j = 0; j < tbl[k].pre_junk; j++) send_pix(0, 8'($urandom), 1'b0);
            if (tbl[k].partial > 0) send_frame(tbl[k].gap_pct, tbl[k].partial);
            for (int f = 0; f < tbl[k].frames; f++) send_frame(tbl[k].gap_pct, W * H);
            repeat (3) step(1'b0, 8'h00, 1'b0);
            expect_int($sformatf("scen%0d_windows", k), win_cnt, tbl[k].exp_win);
            expect_int($sformatf("scen%0d_hsync", k), hs_cnt, tbl[k].exp_hs);
            expect_int($sformatf("scen%0d_vsync", k), vs_cnt, tbl[k].exp_vs);
`ifdef SOBEL_FRAME_ERR_EN
            expect_int($sformatf("scen%0d_frame_err", k), ferr_cnt, tbl[k].exp_ferr);
`endif
            if (tbl[k].chk_first) begin
                n_checks++;
                if (first_w !== FIRST_WIN) begin
                    n_errors++;
                    $display("FAIL scen%0d_first_window got %h want %h", k, first_w, FIRST_WIN);
                end
            end
            if (tbl[k].frames == 2)
                expect_int("frame1_last_p8", int'(w24_p8), 47);
        end

        // Reset asserted mid-frame at (4,3), stale tail discarded, fresh frame afterwards.
        clear_counts();
        send_frame(0, 4 * W + 3);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({win_valid, hsync, vsync, p0, p1, p2, p3, p5, p6, p7, p8} !== '0) begin
            n_errors++;
            $display("FAIL async_reset got %b%b%b %h want all zero", win_valid, hsync, vsync,
                     {p0, p1, p2, p3, p5, p6, p7, p8});
        end
        repeat (3) step(1'b1, 8'hAA, 1'b0);
        rst = 1'b1;
        clear_counts();
        for (int i = 4 * W + 3; i < W * H; i++) send_pix(0, 8'(i), 1'b0);
        expect_int("post_reset_no_windows", win_cnt, 0);
        send_frame(10, W * H);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        expect_int("post_reset_windows", win_cnt, 24);
        expect_int("post_reset_hsync", hs_cnt, 4);
        expect_int("post_reset_vsync", vs_cnt, 1);
        n_checks++;
        if (first_w !== FIRST_WIN) begin
            n_errors++;
            $display("FAIL post_reset_first_window got %h want %h", first_w, FIRST_WIN);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
